rv_tb_mem_loader: RTL and testbench

- Synthesizable unified instruction/data memory responder for rv_core_single_cycle.
- Serves the core's IMEM fetch port and its DMEM load/store port from one word-organised array.
- Contains a loader state machine that zero-clears the array, then accepts a program image as a stream of 32-bit words over a valid/ready interface.
- Holds the core in reset until loading completes. Replaces simulator-only memory loading so test images can be streamed in from a host or UART bridge.

---
 rtl/rv_tb_mem_loader.sv | 151 +++++++++++++++
 tb/tb_rv_tb_mem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_tb_mem_loader.sv
// Unified IMEM/DMEM word array with clear-then-load streaming loader; reads are 1-cycle registered, read-first.
// Loader is ready only in LOAD; no stall path to the core, which is simply held in reset until the image is in place.
`timescale 1ns/1ps
module rv_tb_mem_loader #(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_W      = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start_i,
   input  logic        load_valid_i,
   input  logic [31:0] load_data_i,
   input  logic        load_last_i,
   output logic        load_ready_o,
   output logic        load_done_o,
   output logic        load_trunc_o,
   output logic        core_hold_o,
   input  logic [31:0] IMEM_addr_i,
   output logic [31:0] IMEM_data_o,
   input  logic [31:0] DMEM_addr_i,
   input  logic        DMEM_wr_en_i,
   input  logic [3:0]  DMEM_wr_byte_en_i,
   input  logic [31:0] DMEM_wr_data_i,
   output logic [31:0] DMEM_rd_data_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DONE,
      S_RUN
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              trunc_q, trunc_d;
   logic              hold_q, hold_d;
   logic [31:0]       imem_q, dmem_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              ld_we;
   logic [31:0]       ld_wdata;
   logic [ADDR_W-1:0] imem_idx, dmem_idx;
   logic              run_w;
   logic              unused_addr_bits;

   // Byte addresses wrap modulo the array size; low two bits select nothing.
   assign imem_idx = IMEM_addr_i[ADDR_W+1:2];
   assign dmem_idx = DMEM_addr_i[ADDR_W+1:2];
   assign unused_addr_bits = ^{IMEM_addr_i[31:ADDR_W+2], IMEM_addr_i[1:0],
                               DMEM_addr_i[31:ADDR_W+2], DMEM_addr_i[1:0]};

   assign run_w = (state_q == S_RUN);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      trunc_d  = trunc_q;
      ld_we    = 1'b0;
      ld_wdata = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
               trunc_d = 1'b0;
            end
         end
         S_CLEAR: begin
            ld_we = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) begin
               state_d = S_LOAD;
               ptr_d   = '0;
            end
         end
         S_LOAD: begin
            if (load_valid_i) begin
               ld_we    = 1'b1;
               ld_wdata = load_data_i;
               ptr_d    = ptr_q + 1'b1;
               if (load_last_i) begin
                  state_d = S_DONE;
               end else if (ptr_q == LAST_IDX) begin
                  // Array full before the host marked the last word.
                  state_d = S_DONE;
                  trunc_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (load_start_i) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
               trunc_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      hold_d = (state_d != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         trunc_q <= 1'b0;
         hold_q  <= 1'b1;
         imem_q  <= 32'h0;
         dmem_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         trunc_q <= trunc_d;
         hold_q  <= hold_d;
         imem_q  <= run_w ? mem_q[imem_idx] : 32'h0;
         dmem_q  <= run_w ? mem_q[dmem_idx] : 32'h0;
      end
   end

   // Array has no reset; writes are gated by rst so a reset edge never commits a beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ld_we) begin
            mem_q[ptr_q] <= ld_wdata;
         end else if (run_w && DMEM_wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
               if (DMEM_wr_byte_en_i[b]) begin
                  mem_q[dmem_idx][8*b +: 8] <= DMEM_wr_data_i[8*b +: 8];
               end
            end
         end
      end
   end

   assign load_ready_o   = (state_q == S_LOAD);
   assign load_done_o    = (state_q == S_DONE);
   assign load_trunc_o   = trunc_q;
   assign core_hold_o    = hold_q;
   assign IMEM_data_o    = imem_q;
   assign DMEM_rd_data_o = dmem_q;

endmodule

// File: tb/tb_rv_tb_mem_loader.sv
// Directed bench for rv_tb_mem_loader (16-word array); read responses checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_rv_tb_mem_loader;
   localparam int DW = 16;
   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start_i, load_valid_i, load_last_i;
   logic [31:0] load_data_i;
   logic        load_ready_o, load_done_o, load_trunc_o, core_hold_o;
   logic [31:0] IMEM_addr_i, IMEM_data_o;
   logic [31:0] DMEM_addr_i, DMEM_wr_data_i, DMEM_rd_data_o;
   logic        DMEM_wr_en_i;
   logic [3:0]  DMEM_wr_byte_en_i;

   always #5 clk = ~clk;

   rv_tb_mem_loader #(.DEPTH_WORDS(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .load_start_i(load_start_i), .load_valid_i(load_valid_i),
      .load_data_i(load_data_i), .load_last_i(load_last_i),
      .load_ready_o(load_ready_o), .load_done_o(load_done_o),
      .load_trunc_o(load_trunc_o), .core_hold_o(core_hold_o),
      .IMEM_addr_i(IMEM_addr_i), .IMEM_data_o(IMEM_data_o),
      .DMEM_addr_i(DMEM_addr_i), .DMEM_wr_en_i(DMEM_wr_en_i),
      .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i), .DMEM_wr_data_i(DMEM_wr_data_i),
      .DMEM_rd_data_o(DMEM_rd_data_o)
   );

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [31:0] imem_exp_q[$];
   logic [31:0] dmem_exp_q[$];
   string       imem_nm_q[$];
   string       dmem_nm_q[$];
   logic        imem_req = 1'b0, dmem_req = 1'b0;
   logic        imem_req_q = 1'b0, dmem_req_q = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // A read request issued in one cycle is answered after the next rising edge.
   always @(posedge clk) begin
      imem_req_q <= imem_req;
      dmem_req_q <= dmem_req;
   end

   always @(negedge clk) begin
      logic [31:0] e;
      string       nm;
      if (load_done_o) done_cnt++;
      if (imem_req_q) begin
         if (imem_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL imem_sb_underflow: got response with no expected entry");
         end else begin
            e = imem_exp_q.pop_front(); nm = imem_nm_q.pop_front();
            chk(nm, IMEM_data_o, e);
         end
      end
      if (dmem_req_q) begin
         if (dmem_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dmem_sb_underflow: got response with no expected entry");
         end else begin
            e = dmem_exp_q.pop_front(); nm = dmem_nm_q.pop_front();
            chk(nm, DMEM_rd_data_o, e);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      imem_req = 1'b0;
      dmem_req = 1'b0;
   endtask

   task automatic exp_i(input logic [31:0] a, input logic [31:0] e, input string nm);
      IMEM_addr_i = a; imem_req = 1'b1;
      imem_exp_q.push_back(e); imem_nm_q.push_back(nm);
   endtask

   task automatic exp_d(input logic [31:0] a, input logic [31:0] e, input string nm);
      DMEM_addr_i = a; dmem_req = 1'b1;
      dmem_exp_q.push_back(e); dmem_nm_q.push_back(nm);
   endtask

   task automatic pulse_start();
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
   endtask

   // Returns cycles from the start pulse's sampling edge to load_ready_o high.
   task automatic wait_ready(output int n);
      n = 1;
      while (!load_ready_o && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last, output logic acc);
      load_valid_i = 1'b1; load_data_i = d; load_last_i = last;
      acc = load_ready_o;
      tick();
      load_valid_i = 1'b0; load_last_i = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      DMEM_addr_i = a; DMEM_wr_en_i = 1'b1; DMEM_wr_byte_en_i = be; DMEM_wr_data_i = d;
      tick();
      DMEM_wr_en_i = 1'b0; DMEM_wr_byte_en_i = 4'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, d0, acc_cnt;
      logic acc, late_acc;

      rst = 1'b1; load_start_i = 1'b1; load_valid_i = 1'b0; load_last_i = 1'b0;
      load_data_i = 32'h0; IMEM_addr_i = 32'h0; DMEM_addr_i = 32'h0;
      DMEM_wr_en_i = 1'b0; DMEM_wr_byte_en_i = 4'h0; DMEM_wr_data_i = 32'h0;
      tick(); tick();
      chk("rst_ready", load_ready_o, 0);
      chk("rst_done", load_done_o, 0);
      chk("rst_trunc", load_trunc_o, 0);
      chk("rst_hold", core_hold_o, 1);
      chk("rst_imem", IMEM_data_o, 0);
      chk("rst_dmem", DMEM_rd_data_o, 0);
      rst = 1'b0; load_start_i = 1'b0;
      repeat (20) tick();
      chk("start_in_rst_ignored_ready", load_ready_o, 0);
      chk("start_in_rst_ignored_hold", core_hold_o, 1);

      // Clear then a three-word image
      d0 = done_cnt;
      pulse_start();
      wait_ready(n);
      chk("ready_latency", n, 17);
      send(32'h00000013, 1'b0, acc);
      send(32'hDEADBEEF, 1'b0, acc);
      send(32'h12345678, 1'b1, acc);
      chk("done_after_last", load_done_o, 1);
      chk("ready_low_in_done", load_ready_o, 0);
      chk("hold_in_done", core_hold_o, 1);
      tick();
      chk("done_one_cycle", load_done_o, 0);
      chk("hold_released", core_hold_o, 0);
      chk("trunc_clear", load_trunc_o, 0);
      exp_i(32'h0, 32'h00000013, "imem_0x0"); tick();
      exp_i(32'h4, 32'hDEADBEEF, "imem_0x4"); tick();
      exp_i(32'h8, 32'h12345678, "imem_0x8"); tick();
      exp_i(32'hC, 32'h00000000, "imem_0xC"); tick();
      exp_i(32'h40, 32'h00000013, "imem_wrap_0x40"); tick();
      exp_i(32'h6, 32'hDEADBEEF, "imem_unaligned_0x6"); tick();
      chk("done_pulse_count", done_cnt - d0, 1);

      // Byte-lane stores
      store(32'h10, 4'hF, 32'hAABBCCDD);
      store(32'h10, 4'h2, 32'h00001100);
      store(32'h10, 4'h8, 32'h77000000);
      exp_d(32'h10, 32'h77BB11DD, "dmem_be_0x10"); tick();
      exp_d(32'h13, 32'h77BB11DD, "dmem_be_0x13"); tick();
      store(32'h14, 4'h0, 32'hFFFFFFFF);
      exp_d(32'h14, 32'h00000000, "dmem_be0_nowrite"); tick();

      // Read-during-write, same index on both ports
      exp_i(32'h10, 32'h77BB11DD, "rdw_imem_old");
      exp_d(32'h10, 32'h77BB11DD, "rdw_dmem_old");
      store(32'h10, 4'hF, 32'h00000055);
      exp_i(32'h10, 32'h00000055, "rdw_imem_new");
      exp_d(32'h10, 32'h00000055, "rdw_dmem_new"); tick();

      // Reload from RUN, overflowing image with random gaps
      pulse_start();
      chk("hold_on_reload", core_hold_o, 1);
      wait_ready(n);
      chk("reload_ready_latency", n, 17);
      d0 = done_cnt; acc_cnt = 0; late_acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(32'hA0000000 + i, 1'b0, acc);
         if (acc) acc_cnt++;
         if (i >= 16) late_acc = late_acc | acc | load_ready_o;
      end
      repeat (3) tick();
      chk("trunc_accepted", acc_cnt, 16);
      chk("trunc_flag", load_trunc_o, 1);
      chk("trunc_done_count", done_cnt - d0, 1);
      chk("trunc_late_beats_rejected", late_acc, 0);
      chk("trunc_hold_released", core_hold_o, 0);
      for (int i = 0; i < DW; i++) begin
         exp_d(32'(i * 4), 32'hA0000000 + i, $sformatf("trunc_word_%0d", i));
         tick();
      end

      // Reset in the middle of a load, then a clean two-word reload
      pulse_start();
      wait_ready(n);
      for (int i = 0; i < 5; i++) send(32'hB0 + i, 1'b0, acc);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_hold", core_hold_o, 1);
      chk("midrst_ready", load_ready_o, 0);
      chk("midrst_trunc", load_trunc_o, 0);
      exp_d(32'h0, 32'h0, "midrst_dmem_zero");
      store(32'h0, 4'hF, 32'hFFFFFFFF);
      repeat (20) tick();
      chk("midrst_stays_idle", load_ready_o, 0);
      pulse_start();
      wait_ready(n);
      chk("midrst_reload_latency", n, 17);
      send(32'hC0, 1'b0, acc);
      send(32'hC1, 1'b1, acc);
      tick();
      chk("reload_trunc", load_trunc_o, 0);
      chk("reload_hold", core_hold_o, 0);
      for (int i = 0; i < DW; i++) begin
         exp_d(32'(i * 4), (i < 2) ? 32'hC0 + i : 32'h0, $sformatf("reload_word_%0d", i));
         tick();
      end
      repeat (3) tick();
      chk("scoreboard_drained", imem_exp_q.size() + dmem_exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
